// File: rtl/demux1to4_tdm.sv
// Receive-side TDM deinterleaver: rebuilds one W-bit word per lane from a
// round-robin serial stream (slot order 0,1,2,3) and presents all four at once.
module demux1to4_tdm #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    input  logic         din_valid,
    input  logic         sof,
    output logic         s1,
    output logic         s0,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3,
    output logic         out_valid,
    output logic         frame_err,
    output logic         busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [1:0]    slot;
    logic [CW-1:0] bit_cnt;
    logic [W-1:0]  lane [0:3];

    // MSB-first shift; concatenation keeps x/z on din exactly as received.
    function automatic logic [W-1:0] shift_in(input logic [W-1:0] r, input logic b);
        logic [W:0] tmp;
        tmp = {r, b};
        return tmp[W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            slot      <= 2'd0;
            bit_cnt   <= '0;
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lane[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            if (din_valid) begin
                if (sof) begin
                    // A sof always restarts the frame, even on what would be the completing bit.
                    if (state == RUN) begin
                        frame_err <= 1'b1;
                    end
                    lane[0] <= shift_in('0, din);
                    lane[1] <= '0;
                    lane[2] <= '0;
                    lane[3] <= '0;
                    slot    <= 2'd1;
                    bit_cnt <= '0;
                    state   <= RUN;
                end else if (state == RUN) begin
                    if (slot == 2'd3 && bit_cnt == LAST_BIT) begin
                        out0      <= lane[0];
                        out1      <= lane[1];
                        out2      <= lane[2];
                        out3      <= shift_in(lane[3], din);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                        slot      <= 2'd0;
                        bit_cnt   <= '0;
                        for (int i = 0; i < 4; i++) begin
                            lane[i] <= '0;
                        end
                    end else begin
                        lane[slot] <= shift_in(lane[slot], din);
                        slot       <= slot + 2'd1;
                        if (slot == 2'd3) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign s1   = slot[1];
    assign s0   = slot[0];
    assign busy = (state == RUN);

endmodule

// File: tb/tb_demux1to4_tdm.sv
// Directed bench for demux1to4_tdm (W=8) plus a mux loopback driven by the
// block's own slot select.
module tb_demux1to4_tdm;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         din;
    logic         din_valid;
    logic         sof;
    logic         s1;
    logic         s0;
    logic [W-1:0] out0;
    logic [W-1:0] out1;
    logic [W-1:0] out2;
    logic [W-1:0] out3;
    logic         out_valid;
    logic         frame_err;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses;
    int ferrs;
    int ferr_cyc;
    int pulse_cyc [$];

    demux1to4_tdm #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .sof       (sof),
        .s1        (s1),
        .s0        (s0),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, take the edge, observe 1 time unit later.
    task automatic send_bit(input logic v, input logic s, input logic d);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid === 1'b1) begin
            pulses++;
            pulse_cyc.push_back(cyc);
        end
        if (frame_err === 1'b1) begin
            ferrs++;
            ferr_cyc = cyc;
        end
    endtask

    // Sends one full frame (sof on the first bit), optionally with a gap cycle before each bit.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input bit gap, output int slot_bad);
        logic [7:0] w [4];
        logic [1:0] exp_slot;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        slot_bad = 0;
        for (int bi = 0; bi < 8; bi++) begin
            for (int l = 0; l < 4; l++) begin
                if (gap) begin
                    send_bit(1'b0, 1'b0, 1'b0);
                    if ({s1, s0} !== 2'(l)) slot_bad++;
                end
                send_bit(1'b1, (bi == 0 && l == 0), w[l][7-bi]);
                exp_slot = (bi == 7 && l == 3) ? 2'd0 : 2'((l + 1) % 4);
                if ({s1, s0} !== exp_slot) slot_bad++;
            end
        end
    endtask

    task automatic clear_obs();
        pulses = 0;
        ferrs  = 0;
        ferr_cyc = -1;
        pulse_cyc.delete();
    endtask

    function automatic int pulse_at(input int idx);
        return (pulse_cyc.size() > idx) ? pulse_cyc[idx] : -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        total++;
        if ({out0, out1, out2, out3} !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_outs got=%h want=0", {out0, out1, out2, out3});
        end
        total++;
        if ({s1, s0, busy, out_valid, frame_err} !== 5'b0) begin
            bad++; $display("[TB] FAIL reset_ctrl got=%b want=00000", {s1, s0, busy, out_valid, frame_err});
        end
    endtask

    task automatic test_idle_drop();
        clear_obs();
        for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0, k[0]);
        total++;
        if ({s1, s0, busy} !== 3'b000 || pulses != 0) begin
            bad++; $display("[TB] FAIL idle_drop slot_busy=%b pulses=%0d want=000/0", {s1, s0, busy}, pulses);
        end
    endtask

    task automatic test_single_frame();
        int sb, start;
        clear_obs();
        start = cyc;
        run_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0, sb);
        total++;
        if (sb != 0) begin bad++; $display("[TB] FAIL single_slot errors=%0d want=0", sb); end
        total++;
        if (pulses != 1 || pulse_at(0) != start + 32) begin
            bad++; $display("[TB] FAIL single_valid pulses=%0d at=%0d want=1 at %0d", pulses, pulse_at(0), start + 32);
        end
        total++;
        if ({out0, out1, out2, out3} !== 32'hA53CFF01) begin
            bad++; $display("[TB] FAIL single_outs got=%h want=a53cff01", {out0, out1, out2, out3});
        end
        total++;
        if (ferrs != 0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL single_err ferrs=%0d busy=%b want=0/0", ferrs, busy);
        end
        send_bit(1'b0, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b0 || {out0, out1, out2, out3} !== 32'hA53CFF01) begin
            bad++; $display("[TB] FAIL single_hold valid=%b outs=%h want=0/a53cff01", out_valid, {out0, out1, out2, out3});
        end
    endtask

    task automatic test_gapped();
        int sb, start;
        rst = 1'b1;
        send_bit(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        clear_obs();
        start = cyc;
        run_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b1, sb);
        total++;
        if (sb != 0) begin bad++; $display("[TB] FAIL gapped_slot errors=%0d want=0", sb); end
        total++;
        if (pulses != 1 || pulse_at(0) != start + 64) begin
            bad++; $display("[TB] FAIL gapped_valid pulses=%0d at=%0d want=1 at %0d", pulses, pulse_at(0), start + 64);
        end
        total++;
        if ({out0, out1, out2, out3} !== 32'hA53CFF01) begin
            bad++; $display("[TB] FAIL gapped_outs got=%h want=a53cff01", {out0, out1, out2, out3});
        end
    endtask

    task automatic test_premature_sof();
        int sb, start;
        clear_obs();
        for (int k = 0; k < 12; k++) send_bit(1'b1, (k == 0), k[0]);
        total++;
        if (busy !== 1'b1) begin bad++; $display("[TB] FAIL premature_busy got=%b want=1", busy); end
        start = cyc;
        run_frame(8'h11, 8'h22, 8'h44, 8'h88, 1'b0, sb);
        total++;
        if (ferrs != 1 || ferr_cyc != start + 1) begin
            bad++; $display("[TB] FAIL premature_err count=%0d at=%0d want=1 at %0d", ferrs, ferr_cyc, start + 1);
        end
        total++;
        if (pulses != 1 || pulse_at(0) != start + 32 || sb != 0) begin
            bad++; $display("[TB] FAIL premature_valid pulses=%0d at=%0d slotbad=%0d want=1 at %0d", pulses, pulse_at(0), sb, start + 32);
        end
        total++;
        if ({out0, out1, out2, out3} !== 32'h11224488) begin
            bad++; $display("[TB] FAIL premature_outs got=%h want=11224488", {out0, out1, out2, out3});
        end
    endtask

    task automatic test_sof_on_last();
        int sb, start;
        clear_obs();
        for (int k = 0; k < 31; k++) send_bit(1'b1, (k == 0), ~k[1]);
        start = cyc;
        run_frame(8'h5A, 8'hC3, 8'h81, 8'h7E, 1'b0, sb);
        total++;
        if (ferrs != 1 || ferr_cyc != start + 1) begin
            bad++; $display("[TB] FAIL lastsof_err count=%0d at=%0d want=1 at %0d", ferrs, ferr_cyc, start + 1);
        end
        total++;
        if (pulses != 1 || pulse_at(0) != start + 32 || sb != 0) begin
            bad++; $display("[TB] FAIL lastsof_valid pulses=%0d at=%0d slotbad=%0d want=1 at %0d", pulses, pulse_at(0), sb, start + 32);
        end
        total++;
        if ({out0, out1, out2, out3} !== 32'h5AC3817E) begin
            bad++; $display("[TB] FAIL lastsof_outs got=%h want=5ac3817e", {out0, out1, out2, out3});
        end
    endtask

    task automatic test_back_to_back();
        int sb1, sb2;
        clear_obs();
        run_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0, sb1);
        total++;
        if ({out0, out1, out2, out3} !== 32'hA53CFF01) begin
            bad++; $display("[TB] FAIL b2b_first got=%h want=a53cff01", {out0, out1, out2, out3});
        end
        run_frame(8'h00, 8'hFF, 8'h0F, 8'hF0, 1'b0, sb2);
        total++;
        if (pulses != 2 || pulse_at(1) - pulse_at(0) != 32 || sb1 != 0 || sb2 != 0) begin
            bad++; $display("[TB] FAIL b2b_valid pulses=%0d gap=%0d slotbad=%0d want=2 gap 32", pulses, pulse_at(1) - pulse_at(0), sb1 + sb2);
        end
        total++;
        if ({out0, out1, out2, out3} !== 32'h00FF0FF0 || ferrs != 0) begin
            bad++; $display("[TB] FAIL b2b_second got=%h ferrs=%0d want=00ff0ff0/0", {out0, out1, out2, out3}, ferrs);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_obs();
        for (int k = 0; k < 20; k++) send_bit(1'b1, (k == 0), 1'b1);
        rst = 1'b1;
        send_bit(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        total++;
        if ({out0, out1, out2, out3} !== 32'h0 || {s1, s0, busy} !== 3'b000 || pulses != 0) begin
            bad++; $display("[TB] FAIL midreset got=%h ctrl=%b pulses=%0d want=0/000/0", {out0, out1, out2, out3}, {s1, s0, busy}, pulses);
        end
        for (int k = 0; k < 12; k++) send_bit(1'b1, 1'b0, 1'b1);
        total++;
        if ({s1, s0, busy} !== 3'b000 || pulses != 0 || {out0, out1, out2, out3} !== 32'h0) begin
            bad++; $display("[TB] FAIL midreset_ignore ctrl=%b pulses=%0d outs=%h want=000/0/0", {s1, s0, busy}, pulses, {out0, out1, out2, out3});
        end
    endtask

    // Transmit mux modelled in the bench, selected by the DUT's own s1/s0.
    task automatic test_loopback();
        logic [7:0] w [4];
        logic [1:0] sel;
        for (int f = 0; f < 2000; f++) begin
            for (int l = 0; l < 4; l++) w[l] = 8'($urandom);
            if (f == 777) w[2] = 8'b10x1_0z01;
            for (int bi = 0; bi < 8; bi++) begin
                for (int l = 0; l < 4; l++) begin
                    sel = {s1, s0};
                    send_bit(1'b1, (bi == 0 && l == 0), w[sel][7-bi]);
                end
            end
            total++;
            if (out_valid !== 1'b1 || out0 !== w[0] || out1 !== w[1] || out2 !== w[2] || out3 !== w[3]) begin
                bad++;
                $display("[TB] FAIL loopback frame=%0d valid=%b got=%h %h %h %h want=%h %h %h %h",
                         f, out_valid, out0, out1, out2, out3, w[0], w[1], w[2], w[3]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        sof       = 1'b0;
        clear_obs();
        test_reset();
        test_idle_drop();
        test_single_frame();
        test_gapped();
        test_premature_sof();
        test_sof_on_last();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux1to4_tdm.md
Name: demux1to4_tdm

Overview:
- Receive-side counterpart of the 4-to-1 select mux: deinterleaves a serial time-division stream into four parallel lanes.
- The transmit side drives one bit per slot, round-robin over lanes 0..3 (select order 00, 01, 10, 11). This block rebuilds one W-bit word per lane and presents all four words together with a single-cycle valid.
- Used in the mux/demux loopback benches, with its s1/s0 outputs driving the mux select.

Parameters:
- W, 8, bits per lane per frame (frame length = 4*W valid bits); legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- din  input  1  serial data bit; sampled only when din_valid=1
- din_valid  input  1  din qualifier; one bit accepted per cycle when high
- sof  input  1  start of frame; meaningful only with din_valid=1; marks slot 0, bit 0
- s1  output  1  MSB of slot for the next expected bit
- s0  output  1  LSB of slot for the next expected bit
- out0  output  W  lane 0 word, last completed frame
- out1  output  W  lane 1 word
- out2  output  W  lane 2 word
- out3  output  W  lane 3 word
- out_valid  output  1  one-cycle pulse: out0..out3 updated
- frame_err  output  1  one-cycle pulse: frame aborted by premature sof
- busy  output  1  1 while in RUN

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; slot=0 ({s1,s0}=00); bit counter=0; out0..out3=0; out_valid=0; frame_err=0; busy=0; lane shift registers cleared.
- Reset mid-frame: the partial frame is discarded with no out_valid. out0..out3 return to 0.
- Accepted bit = clock edge with din_valid=1. Cycles with din_valid=0 change no state, and slot/counter hold.
- State IDLE:
  - Accepted bit with sof=1: stored as lane 0 bit 0; slot goes to 1; state goes to RUN.
  - Accepted bit with sof=0: dropped, no other effect.
- State RUN:
  - Each accepted bit is shifted into the lane register selected by the current slot, MSB-first. The first bit of a lane ends up in bit W-1.
  - Slot increments mod 4 after every accepted bit. The bit counter increments after slot 3.
- Frame completion: when the accepted bit is slot 3 of bit W-1 (the 4*W-th bit), on the next edge:
  - out0..out3 load the four lane words;
  - out_valid=1 for exactly one cycle;
  - state goes to IDLE; slot=0.
- Back-to-back frames: a sof bit in the cycle immediately after completion is accepted normally, so there are no dead cycles.
- sof=1 on an accepted bit while in RUN:
  - frame_err pulses for one cycle at the next edge;
  - the partial frame is discarded and out0..out3 are not updated;
  - that bit is taken as lane 0 bit 0 of a new frame (slot goes to 1; stays in RUN).
  - sof=1 on the completing bit itself counts as this case, not completion.
- Latency: last accepted bit at edge N gives out_valid high during cycle N+1.
- out0..out3 hold their value until the next completion or reset.
- s1/s0 and busy are registered and reflect state after each edge.
- 4-state handling: din=x/z is stored as-is; no sanitising. sof or din_valid=x is undefined and is not checked by the bench.
- All outputs are registered; there is no combinational input-to-output path.

Test Plan:
- Reset then single frame, W=8: sof on first bit; lanes carry 0xA5, 0x3C, 0xFF, 0x01 interleaved (32 bits, din_valid=1 each cycle) -> out_valid pulses once, 1 cycle after bit 32; out0=A5, out1=3C, out2=FF, out3=01; frame_err=0.
- Gapped valid: same frame with din_valid=0 on every other cycle -> identical outputs; s1/s0 hold during gaps; out_valid 1 cycle after last valid bit.
- Premature sof: start a frame, assert sof on bit 13, then send a full 0x11/0x22/0x44/0x88 frame from there -> frame_err pulses once at bit 13+1; single out_valid with out0=11, out1=22, out2=44, out3=88.
- Back-to-back: two frames with no idle cycle (second = 0x00/0xFF/0x0F/0xF0) -> two out_valid pulses exactly 32 cycles apart; outputs switch to the second set.
- Reset mid-frame: rst=1 after bit 20 -> no out_valid; out0..out3=0, {s1,s0}=00, busy=0; bits without sof are then ignored until the next sof.
- Loopback: drive the 4-to-1 mux with this block's s1/s0 and random 8-bit lane words, 2000 frames -> every out word equals its source word (compare with !==, x propagated).
